gpio_serial_loader: RTL and testbench

- Hardware sequencer for the GPIO configuration serial chains.
- Two chains: user1 (GPIO 0..18) and user2 (GPIO 37..19). Each pad holds a 13-bit config word.
- Replaces SPI bit-banging with an automatic transfer:
  - fetches each pad's config word from the housekeeping config register file,
  - shifts the words into both chains in parallel,
  - pulses load.
- Sits in housekeeping between the config register file and the serial_clock/serial_load/serial_resetn/serial_data_1/serial_data_2 lines.

---
 rtl/gpio_serial_loader.sv | 212 +++++++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : gpio_serial_loader
// Description : Shifts per-pad GPIO config words into the two housekeeping
//               serial chains in parallel, farthest pad first, then pulses load.
//               Optional bit-bang override: GPIO_LOADER_BITBANG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_serial_loader #(
    parameter int NPADS   = 19,
    parameter int WBITS   = 13,
    parameter int CLK_DIV = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             xfer_start,
    output logic             busy,
    output logic             done,
    output logic [4:0]       cfg_idx,
    input  logic [WBITS-1:0] cfg_data_1,
    input  logic [WBITS-1:0] cfg_data_2,
    input  logic             bb_en,
    input  logic             bb_clock,
    input  logic             bb_load,
    input  logic             bb_resetn,
    input  logic             bb_data_1,
    input  logic             bb_data_2,
    output logic             serial_clock,
    output logic             serial_load,
    output logic             serial_resetn,
    output logic             serial_data_1,
    output logic             serial_data_2
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = (WBITS > 1) ? $clog2(WBITS) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WBITS - 1);
    localparam logic [4:0]         c_PAD_LAST = 5'(NPADS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SETUP, S_CLKHI, S_LOAD, S_LOADLO, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_DIV_W-1:0] r_div, w_div_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic [WBITS-1:0]   r_sreg1, w_sreg1_nxt, r_sreg2, w_sreg2_nxt;
    logic [4:0]         r_cfg_idx, w_cfg_idx_nxt;
    logic               r_busy, w_busy_nxt, r_done, w_done_nxt;
    logic               r_sclk, w_sclk_nxt, r_sload, w_sload_nxt;
    logic               r_sd1, w_sd1_nxt, r_sd2, w_sd2_nxt;
    logic               r_sresetn;
    logic               w_div_wrap, w_abort, w_start_ok;

`ifdef GPIO_LOADER_BITBANG_EN
    assign w_abort    = bb_en;
    assign w_start_ok = xfer_start & ~bb_en;
`else
    assign w_abort    = 1'b0;
    assign w_start_ok = xfer_start;
`endif

    assign w_div_wrap = (r_div == c_DIV_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = '0;
        w_bit_nxt     = r_bit;
        w_sreg1_nxt   = r_sreg1;
        w_sreg2_nxt   = r_sreg2;
        w_cfg_idx_nxt = r_cfg_idx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_sclk_nxt    = r_sclk;
        w_sload_nxt   = r_sload;
        w_sd1_nxt     = r_sd1;
        w_sd2_nxt     = r_sd2;

        case (r_state)
            S_IDLE: begin
                if (r_done) w_busy_nxt = 1'b0;
                if (w_start_ok && !r_busy) begin
                    w_state_nxt   = S_FETCH;
                    w_cfg_idx_nxt = c_PAD_LAST;
                    w_busy_nxt    = 1'b1;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                // Present the MSB immediately so it is stable through SETUP.
                w_sreg1_nxt = cfg_data_1;
                w_sreg2_nxt = cfg_data_2;
                w_sd1_nxt   = cfg_data_1[WBITS-1];
                w_sd2_nxt   = cfg_data_2[WBITS-1];
                w_bit_nxt   = c_BIT_LAST;
                w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_div_nxt = w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_CLKHI;
                end
            end
            S_CLKHI: begin
                w_div_nxt = w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) begin
                    w_sclk_nxt  = 1'b0;
                    w_sreg1_nxt = {r_sreg1[WBITS-2:0], 1'b0};
                    w_sreg2_nxt = {r_sreg2[WBITS-2:0], 1'b0};
                    if (r_bit != '0) begin
                        w_bit_nxt   = r_bit - 1'b1;
                        w_sd1_nxt   = r_sreg1[WBITS-2];
                        w_sd2_nxt   = r_sreg2[WBITS-2];
                        w_state_nxt = S_SETUP;
                    end else if (r_cfg_idx != '0) begin
                        w_cfg_idx_nxt = r_cfg_idx - 1'b1;
                        w_state_nxt   = S_FETCH;
                    end else begin
                        w_sload_nxt = 1'b1;
                        w_sd1_nxt   = 1'b0;
                        w_sd2_nxt   = 1'b0;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_div_nxt = w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) begin
                    w_sload_nxt = 1'b0;
                    w_state_nxt = S_LOADLO;
                end
            end
            S_LOADLO: begin
                w_div_nxt = w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_abort) begin
            w_state_nxt   = S_IDLE;
            w_div_nxt     = '0;
            w_cfg_idx_nxt = '0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_sclk_nxt    = 1'b0;
            w_sload_nxt   = 1'b0;
            w_sd1_nxt     = 1'b0;
            w_sd2_nxt     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_sreg1   <= '0;
            r_sreg2   <= '0;
            r_cfg_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sload   <= 1'b0;
            r_sd1     <= 1'b0;
            r_sd2     <= 1'b0;
            r_sresetn <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_sreg1   <= w_sreg1_nxt;
            r_sreg2   <= w_sreg2_nxt;
            r_cfg_idx <= w_cfg_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sload   <= w_sload_nxt;
            r_sd1     <= w_sd1_nxt;
            r_sd2     <= w_sd2_nxt;
            r_sresetn <= 1'b1;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_idx = r_cfg_idx;

`ifdef GPIO_LOADER_BITBANG_EN
    assign serial_clock  = bb_en ? bb_clock  : r_sclk;
    assign serial_load   = bb_en ? bb_load   : r_sload;
    assign serial_resetn = bb_en ? bb_resetn : r_sresetn;
    assign serial_data_1 = bb_en ? bb_data_1 : r_sd1;
    assign serial_data_2 = bb_en ? bb_data_2 : r_sd2;
`else
    logic w_bb_unused;
    assign w_bb_unused   = ^{bb_en, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2};
    assign serial_clock  = r_sclk;
    assign serial_load   = r_sload;
    assign serial_resetn = r_sresetn;
    assign serial_data_1 = r_sd1;
    assign serial_data_2 = r_sd2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_serial_loader
// Description : Self-checking bench; two loaders (CLK_DIV=2 and CLK_DIV=1)
//               checked against a shadow-chain model of both GPIO chains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_serial_loader;

    localparam int NP   = 19;
    localparam int WB   = 13;
    localparam int NB   = NP * WB;
    localparam int LEN2 = 1 + NP * (2 + 2 * WB * 2) + 2 * 2;
    localparam int LEN1 = 1 + NP * (2 + 2 * WB * 1) + 2 * 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic       bb_en, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2;
    logic [1:0] busy_v, done_v, sclk_v, sload_v, sres_v, sd1_v, sd2_v;
    logic [4:0] idx0, idx1;
    logic [WB-1:0] cd1_0, cd2_0, cd1_1, cd2_1;
    logic [WB-1:0] mem1 [32];
    logic [WB-1:0] mem2 [32];

    gpio_serial_loader #(.NPADS(NP), .WBITS(WB), .CLK_DIV(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start0),
        .busy(busy_v[0]), .done(done_v[0]), .cfg_idx(idx0),
        .cfg_data_1(cd1_0), .cfg_data_2(cd2_0),
        .bb_en(bb_en), .bb_clock(bb_clock), .bb_load(bb_load), .bb_resetn(bb_resetn),
        .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
        .serial_clock(sclk_v[0]), .serial_load(sload_v[0]), .serial_resetn(sres_v[0]),
        .serial_data_1(sd1_v[0]), .serial_data_2(sd2_v[0]));

    gpio_serial_loader #(.NPADS(NP), .WBITS(WB), .CLK_DIV(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start1),
        .busy(busy_v[1]), .done(done_v[1]), .cfg_idx(idx1),
        .cfg_data_1(cd1_1), .cfg_data_2(cd2_1),
        .bb_en(bb_en), .bb_clock(bb_clock), .bb_load(bb_load), .bb_resetn(bb_resetn),
        .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
        .serial_clock(sclk_v[1]), .serial_load(sload_v[1]), .serial_resetn(sres_v[1]),
        .serial_data_1(sd1_v[1]), .serial_data_2(sd2_v[1]));

    // Config register file: one-cycle read latency from cfg_idx.
    always @(posedge clk) begin
        cd1_0 <= mem1[idx0];
        cd2_0 <= mem2[idx0];
        cd1_1 <= mem1[idx1];
        cd2_1 <= mem2[idx1];
    end

    function automatic int divof(input int w);
        return (w == 0) ? 2 : 1;
    endfunction

    int n_rise[2], n_load[2], n_load_hi[2], n_done[2], n_unstable[2], n_short[2], n_long[2];
    int last_rise[2];
    logic [NB-1:0] cha[2], chb[2];
    int cyc;
    logic [1:0] p_clk, p_load, p_d1, p_d2;

    // Observe both chains once per cycle; shadow chains shift on each clock rise.
    initial begin
        int gap;
        cyc = 0;
        p_clk = '0; p_load = '0; p_d1 = '0; p_d2 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (sclk_v[i] && !p_clk[i]) begin
                    if (n_rise[i] > 0) begin
                        gap = cyc - last_rise[i];
                        if (gap == 2 * divof(i)) n_short[i]++;
                        else if (gap == 2 * divof(i) + 2) n_long[i]++;
                    end
                    last_rise[i] = cyc;
                    n_rise[i]++;
                    cha[i] = {cha[i][NB-2:0], sd1_v[i]};
                    chb[i] = {chb[i][NB-2:0], sd2_v[i]};
                    if (sd1_v[i] !== p_d1[i] || sd2_v[i] !== p_d2[i]) n_unstable[i]++;
                end
                if (sload_v[i] && !p_load[i]) n_load[i]++;
                if (sload_v[i]) n_load_hi[i]++;
                if (done_v[i]) n_done[i]++;
            end
            p_clk = sclk_v; p_load = sload_v; p_d1 = sd1_v; p_d2 = sd2_v;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            n_rise[i] = 0; n_load[i] = 0; n_load_hi[i] = 0; n_done[i] = 0;
            n_unstable[i] = 0; n_short[i] = 0; n_long[i] = 0; last_rise[i] = 0;
            cha[i] = '0; chb[i] = '0;
        end
    endtask

    task automatic run_xfer(input int w, input int extra_at, output int len);
        @(negedge clk);
        if (w == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        len = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            if (w == 0) start0 = (k == extra_at);
            if (done_v[w]) begin
                len = k;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    typedef struct {
        int          which;
        int          kind;       // 0 constant words, 1 idx/~idx, 2 random
        logic [WB-1:0] w1, w2;
        int          extra_at;   // cycle of a spurious start, 0 = none
        int          exp_len;
        int          exp_rises;
        int          exp_load_hi;
    } vec_t;

    task automatic do_vec(input vec_t v);
        int len;
        int w;
        w = v.which;
        for (int i = 0; i < 32; i++) begin
            case (v.kind)
                0:       begin mem1[i] = v.w1;           mem2[i] = v.w2; end
                1:       begin mem1[i] = WB'(i);         mem2[i] = ~WB'(i); end
                default: begin mem1[i] = WB'($urandom()); mem2[i] = WB'($urandom()); end
            endcase
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        clear_mon();
        run_xfer(w, v.extra_at, len);
        check("xfer_length", 64'(len), 64'(v.exp_len));
        check("busy_during_done", 64'(busy_v[w]), 64'd1);
        @(posedge clk); #1;
        check("busy_after_done", 64'(busy_v[w]), 64'd0);
        check("done_width", 64'(done_v[w]), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("clock_rises", 64'(n_rise[w]), 64'(v.exp_rises));
        check("load_pulses", 64'(n_load[w]), 64'd1);
        check("load_cycles", 64'(n_load_hi[w]), 64'(v.exp_load_hi));
        check("done_pulses", 64'(n_done[w]), 64'd1);
        check("data_unstable_at_rise", 64'(n_unstable[w]), 64'd0);
        check("bit_periods", 64'(n_short[w]), 64'(NP * (WB - 1)));
        check("pad_gaps", 64'(n_long[w]), 64'(NP - 1));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("chain1_pad%0d", p), 64'(cha[w][p*WB +: WB]), 64'(mem1[p]));
            check($sformatf("chain2_pad%0d", p), 64'(chb[w][p*WB +: WB]), 64'(mem2[p]));
        end
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{which:0, kind:0, w1:13'h1809, w2:13'h0403, extra_at:0,   exp_len:LEN2, exp_rises:NB, exp_load_hi:2};
        tbl[1] = '{which:0, kind:1, w1:13'h0000, w2:13'h0000, extra_at:0,   exp_len:LEN2, exp_rises:NB, exp_load_hi:2};
        tbl[2] = '{which:0, kind:2, w1:13'h0000, w2:13'h0000, extra_at:0,   exp_len:LEN2, exp_rises:NB, exp_load_hi:2};
        tbl[3] = '{which:0, kind:0, w1:13'h1fff, w2:13'h0aaa, extra_at:500, exp_len:LEN2, exp_rises:NB, exp_load_hi:2};
        tbl[4] = '{which:1, kind:2, w1:13'h0000, w2:13'h0000, extra_at:0,   exp_len:LEN1, exp_rises:NB, exp_load_hi:1};
        tbl[5] = '{which:1, kind:1, w1:13'h0000, w2:13'h0000, extra_at:0,   exp_len:LEN1, exp_rises:NB, exp_load_hi:1};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        bb_en = 1'b0; bb_clock = 1'b0; bb_load = 1'b0; bb_resetn = 1'b0;
        bb_data_1 = 1'b0; bb_data_2 = 1'b0;
        for (int i = 0; i < 32; i++) begin mem1[i] = '0; mem2[i] = '0; end
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_cfg_idx", 64'(idx0), 64'd0);
        check("rst_clock", 64'(sclk_v[0]), 64'd0);
        check("rst_load", 64'(sload_v[0]), 64'd0);
        check("rst_resetn", 64'(sres_v[0]), 64'd0);
        check("rst_data", 64'({sd1_v[0], sd2_v[0]}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("resetn_release", 64'(sres_v), 64'd3);

        for (int t = 0; t < 6; t++) do_vec(tbl[t]);

        // Reset in the middle of a transfer: nothing further may be issued.
        clear_mon();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (299) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_clock", 64'(sclk_v[0]), 64'd0);
        check("midrst_resetn", 64'(sres_v[0]), 64'd0);
        check("midrst_cfg_idx", 64'(idx0), 64'd0);
        rst = 1'b0;
        repeat (1200) @(posedge clk);
        #1;
        check("midrst_load_pulses", 64'(n_load[0]), 64'd0);
        check("midrst_done_pulses", 64'(n_done[0]), 64'd0);
        check("midrst_busy_later", 64'(busy_v[0]), 64'd0);
        do_vec(tbl[2]);

        // Reset and start together: reset wins.
        @(negedge clk); rst = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        check("rst_start_busy", 64'(busy_v[0]), 64'd0);
        @(negedge clk); rst = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy_after", 64'(busy_v[0]), 64'd0);

`ifdef GPIO_LOADER_BITBANG_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bb_en = 1'b1; bb_clock = i[0]; bb_data_1 = i[1]; bb_resetn = ~i[0];
            #1;
            check("bb_clock_mirror", 64'(sclk_v[0]), 64'(bb_clock));
            check("bb_data1_mirror", 64'(sd1_v[0]), 64'(bb_data_1));
            check("bb_resetn_mirror", 64'(sres_v[0]), 64'(bb_resetn));
        end
        @(negedge clk); bb_en = 1'b0; #1;
        check("bb_revert", 64'({sclk_v[0], sload_v[0], sres_v[0], sd1_v[0], sd2_v[0]}), 64'b00100);
        clear_mon();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (200) @(posedge clk);
        #1; bb_en = 1'b1;
        @(posedge clk); #1;
        check("bb_abort_busy", 64'(busy_v[0]), 64'd0);
        bb_en = 1'b0;
        repeat (1100) @(posedge clk);
        #1;
        check("bb_abort_done_pulses", 64'(n_done[0]), 64'd0);
        check("bb_abort_idle_outputs", 64'({sclk_v[0], sload_v[0], sres_v[0], sd1_v[0], sd2_v[0]}), 64'b00100);
`else
        @(negedge clk);
        bb_en = 1'b1; bb_clock = 1'b1; bb_data_1 = 1'b1; bb_load = 1'b1; bb_resetn = 1'b0;
        #1;
        check("bb_ignored_outputs", 64'({sclk_v[0], sload_v[0], sres_v[0], sd1_v[0], sd2_v[0]}), 64'b00100);
        @(negedge clk); bb_clock = 1'b0; bb_data_2 = 1'b1; #1;
        check("bb_ignored_outputs2", 64'({sclk_v[0], sload_v[0], sres_v[0], sd1_v[0], sd2_v[0]}), 64'b00100);
        bb_en = 1'b0; bb_load = 1'b0; bb_data_1 = 1'b0; bb_data_2 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
